alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, registered successor to the single-cycle datapath ALU: same control encoding for add/sub/slt, extended with logic ops, signed/unsigned compare and an iterative multiply/divide unit writing HI/LO. It sits in the EX stage of the multicycle MIPS core. A start/busy/done handshake lets the control FSM stall while a multi-cycle operation runs.

## Interface
- WIDTH, 32: operand, result, HI and LO width; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- control  in  4  operation code, sampled with start.
- input1  in  WIDTH  operand A, sampled with start.
- input2  in  WIDTH  operand B, sampled with start.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, combinational from the result register.
- hi  out  WIDTH  HI register (product high half / remainder).
- lo  out  WIDTH  LO register (product low half / quotient).
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result/hi/lo valid.

## Operation
- Control codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1100 NOR; 1001 MULTU; 1010 DIVU; anything else yields result=0.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- SLT/SLTU produce 1 or 0 in bit 0, upper bits zero.
- Single-cycle ops update result only; hi/lo hold.
- MULTU: unsigned shift-add, one bit per cycle; {hi,lo} = input1*input2 (2·WIDTH bits); result = lo.
- DIVU: unsigned restoring division, one bit per cycle; lo = quotient, hi = remainder; result = lo.
- Divide by zero: lo = all ones, hi = input1, same latency as a normal divide.
- FSM states: IDLE, RUN.
  - IDLE + start + single-cycle op: stay in IDLE.
  - IDLE + start + MULTU/DIVU: go to RUN, counter = WIDTH.
  - RUN: decrement each cycle; on the edge where the counter reaches 0, write hi/lo/result and return to IDLE.
- start while busy=1 is ignored; operands and control are not re-sampled.
- Reset: state=IDLE; result, hi, lo, counter and busy are zero, done=0, so zero=1. Reset mid-RUN aborts the operation and discards partial hi/lo.

## Timing
- Start accepted at edge t.
- Single-cycle op: result is updated at edge t, and done=1 for the cycle following t.
- MULTU/DIVU: busy=1 from edge t until edge t+WIDTH. At edge t+WIDTH, hi/lo/result are updated, busy drops and done=1 for one cycle. Latency is WIDTH cycles.
- done and busy are never high together.
- A new start may be accepted in the same cycle done=1 (back-to-back).
- result holds its value between operations; a DIVU/MULTU leaves result unchanged until completion.

## Configuration
- ALU_MDU_DIV_EN defined: DIVU is implemented as described above.
- ALU_MDU_DIV_EN undefined: the divider datapath is omitted. Code 1010 is then treated as an undefined op: result=0, hi/lo unchanged, single-cycle done, no busy.

## Structure
- Package alu_pkg:
  - Control code localparams (ALU_AND … ALU_DIVU).
  - State enum {IDLE, RUN}.
- Sub-module alu_iter holds the shared shift register, adder/subtractor and counter for MULTU/DIVU. It takes a mode input and WIDTH, and produces {hi,lo} plus a finish pulse. The top level holds the FSM, single-cycle ops and handshake.

## Test plan
- Reset, then ADD 5+7 → result=12, zero=0, done one cycle after start. SUB 7−7 → result=0, zero=1.
- SLT 0xFFFFFFFF vs 1 → 1; SLTU on the same operands → 0. NOR 0 vs 0 → 0xFFFFFFFF.
- MULTU 0xFFFFFFFF×2 → busy for 32 cycles, then hi=1, lo=0xFFFFFFFE, done pulse. A start asserted at cycle 10 of the multiply is ignored.
- DIVU 100/7 → lo=14, hi=2 after 32 cycles. DIVU 9/0 → lo=0xFFFFFFFF, hi=9.
- Reset asserted at cycle 15 of a MULTU → next cycle busy=0, done=0, hi=lo=result=0. A following ADD 1+1 completes normally with result=2.
- Back-to-back: a start issued in the done cycle of a MULTU is accepted. Without ALU_MDU_DIV_EN, DIVU 100/7 → result=0, hi/lo unchanged, done after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the EX-stage ALU / multiply-divide unit.
//   - Control-code localparams (same encoding as the single-cycle datapath ALU,
//     extended with logic, compare and MDU operations).
//   - FSM state enum for the handshake controller.
//   - is_iter_op(): tells the controller which codes run on the iterative unit.
//
// Build option:
//   ALU_MDU_DIV_EN  when defined, DIVU (4'b1010) runs on the iterative unit;
//                   when undefined, DIVU is treated as an undefined op.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True for the codes that occupy the iterative unit for WIDTH cycles.
  function automatic logic is_iter_op(input logic [3:0] code);
`ifdef ALU_MDU_DIV_EN
    return (code == ALU_MULTU) || (code == ALU_DIVU);
`else
    return (code == ALU_MULTU);
`endif
  endfunction

endpackage

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
//   Iterative unsigned multiply / divide engine, one bit per cycle.
//   A single {hi,lo} shift register pair and one WIDTH+1 bit adder/subtractor
//   are shared between shift-add multiply and restoring division.
//
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     load         start a new operation (captures a, b, mode; counter=WIDTH)
//     mode         0 = MULTU, 1 = DIVU (ignored unless ALU_MDU_DIV_EN)
//     a, b         multiplicand/multiplier or dividend/divisor
//     hi, lo       value {hi,lo} takes at the next edge; final product
//                  (hi:lo) or remainder (hi) / quotient (lo) when finish=1
//     finish       high in the cycle whose closing edge performs the last step
//
// Build option:
//   ALU_MDU_DIV_EN  includes the divide datapath; otherwise multiply only.
// -----------------------------------------------------------------------------
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             finish
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  // Shared adder/subtractor. One extra bit above the WIDTH+1 operands gives
  // the carry-out, which on subtraction is the "no borrow" (a >= b) flag.
  logic [WIDTH:0]   add_a, add_b;
  logic             add_sub;
  logic [WIDTH+1:0] add_sum;

`ifdef ALU_MDU_DIV_EN
  logic mode_q;
  logic no_borrow;
`else
  logic unused_bits;
  assign unused_bits = mode ^ add_sum[WIDTH+1];
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = {1'b0, b_q};
    add_sub = 1'b0;
`ifdef ALU_MDU_DIV_EN
    if (mode_q) begin
      // Partial remainder shifted left with the next dividend bit.
      add_a   = {hi_q, lo_q[WIDTH-1]};
      add_sub = 1'b1;
    end
`endif
  end

  assign add_sum = {1'b0, add_a}
                 + {1'b0, add_b ^ {(WIDTH+1){add_sub}}}
                 + {{(WIDTH+1){1'b0}}, add_sub};

  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
`ifdef ALU_MDU_DIV_EN
    no_borrow = add_sum[WIDTH+1];
    if (mode_q) begin
      // Restoring step: keep the difference only when it did not go negative.
      // With a zero divisor every step succeeds, which yields an all-ones
      // quotient and leaves the full dividend as the remainder.
      hi_nxt = no_borrow ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], no_borrow};
    end else
`endif
    begin
      // Shift-add step: conditionally add multiplicand, then shift {hi,lo}
      // right by one, catching the adder carry in the top of hi.
      if (lo_q[0]) begin
        hi_nxt = add_sum[WIDTH:1];
        lo_nxt = {add_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_nxt = {1'b0, hi_q[WIDTH-1:1]};
        lo_nxt = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
`ifdef ALU_MDU_DIV_EN
      mode_q <= 1'b0;
`endif
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      cnt_q  <= CNT_W'(WIDTH);
`ifdef ALU_MDU_DIV_EN
      mode_q <= mode;
`endif
    end else if (cnt_q != '0) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign hi     = hi_nxt;
  assign lo     = lo_nxt;
  assign finish = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
//   Registered EX-stage ALU with an iterative multiply/divide unit.
//   Single-cycle ops (AND, OR, ADD, SUB, SLT, SLTU, NOR) update result at the
//   accepting edge. MULTU/DIVU take WIDTH cycles, then write hi, lo and
//   result together. start is only honoured while busy=0.
//
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     start           request, sampled when busy=0
//     control[3:0]    operation code, sampled with start
//     input1, input2  operands A and B, sampled with start
//     result          registered result
//     zero            result == 0
//     hi, lo          product high/low half, or remainder/quotient
//     busy            iterative operation in progress
//     done            one-cycle pulse: result/hi/lo valid
//
// Build option:
//   ALU_MDU_DIV_EN  enables DIVU; otherwise 4'b1010 behaves as an undefined
//                   single-cycle op (result=0, hi/lo held).
// -----------------------------------------------------------------------------
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             done_q;
  logic [WIDTH-1:0] alu_res;
  logic             iter_load, iter_finish;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic             accept_single;

  // Single-cycle datapath. MULTU never reaches here; DIVU only does when the
  // divider is not built, and then falls into the undefined-op default.
  always_comb begin
    alu_res = '0;
    case (control)
      ALU_AND:  alu_res = input1 & input2;
      ALU_OR:   alu_res = input1 | input2;
      ALU_ADD:  alu_res = input1 + input2;
      ALU_SUB:  alu_res = input1 - input2;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, input1 < input2};
      ALU_NOR:  alu_res = ~(input1 | input2);
      default:  alu_res = '0;
    endcase
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iter_load),
    .mode   (control == ALU_DIVU),
    .a      (input1),
    .b      (input2),
    .hi     (iter_hi),
    .lo     (iter_lo),
    .finish (iter_finish)
  );

  always_comb begin
    state_d   = state_q;
    iter_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && is_iter_op(control)) begin
          state_d   = RUN;
          iter_load = 1'b1;
        end
      end
      RUN: begin
        if (iter_finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept_single = (state_q == IDLE) && start && !is_iter_op(control);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept_single) begin
        result_q <= alu_res;
        done_q   <= 1'b1;
      end
      if ((state_q == RUN) && iter_finish) begin
        hi_q     <= iter_hi;
        lo_q     <= iter_lo;
        result_q <= iter_lo;
        done_q   <= 1'b1;
      end
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
//   Directed-vector bench for alu_mdu (WIDTH=32). Inputs change 1 time unit
//   after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       control;
  logic [WIDTH-1:0] input1, input2;
  logic [WIDTH-1:0] result, hi, lo;
  logic             zero, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .control (control),
    .input1  (input1),
    .input2  (input2),
    .result  (result),
    .zero    (zero),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    control = c;
    input1  = a;
    input2  = b;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    issue(c, a, b);
    check({tag, "_res"},  result, exp);
    check({tag, "_done"}, done,   1);
    check({tag, "_busy"}, busy,   0);
  endtask

  // Issues an iterative op and waits (bounded) for done. If ign_at >= 0, a
  // competing ADD start is driven for one edge that many cycles in.
  task automatic run_iter(input string tag, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int ign_at);
    logic [31:0] prev;
    int          n;
    logic        overlap;
    prev    = result;
    overlap = 1'b0;
    issue(c, a, b);
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_done0"}, done, 0);
    n = 0;
    while (n < 100) begin
      if (n == ign_at) begin
        control = ALU_ADD;
        input1  = 32'd1;
        input2  = 32'd1;
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
      if (busy && done) overlap = 1'b1;
      if (n == 5) check({tag, "_hold"}, result, prev);
      if (done) break;
    end
    check({tag, "_lat"},  n,      WIDTH);
    check({tag, "_hi"},   hi,     exp_hi);
    check({tag, "_lo"},   lo,     exp_lo);
    check({tag, "_res"},  result, exp_lo);
    check({tag, "_busy"}, busy,   0);
    check({tag, "_ovl"},  overlap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    control = 4'd0;
    input1  = '0;
    input2  = '0;
    repeat (2) tick();
    check("rst_res",  result, 0);
    check("rst_zero", zero,   1);
    check("rst_hi",   hi,     0);
    check("rst_lo",   lo,     0);
    check("rst_busy", busy,   0);
    check("rst_done", done,   0);
    reset = 1'b0;
    tick();

    single("add", ALU_ADD, 32'd5, 32'd7, 32'd12);
    check("add_zero", zero, 0);
    tick();
    check("add_pulse", done, 0);

    single("sub", ALU_SUB, 32'd7, 32'd7, 32'd0);
    check("sub_zero", zero, 1);
    single("slt",   ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    single("sltu",  ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("nor",   ALU_NOR,  32'd0, 32'd0, 32'hFFFF_FFFF);
    single("and",   ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    single("or",    ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    single("undef", 4'b0011,  32'd5, 32'd5, 32'd0);

    // Start asserted 10 cycles into the multiply must be ignored.
    run_iter("mul1", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 10);
    tick();
    check("mul1_ign_done", done, 0);
    single("add_hold", ALU_ADD, 32'd1, 32'd2, 32'd3);
    check("hold_hi", hi, 32'd1);
    check("hold_lo", lo, 32'hFFFF_FFFE);

    // Back-to-back: issue immediately in the done cycle.
    run_iter("mul2", ALU_MULTU, 32'h1234_5678, 32'h100, 32'h12, 32'h3456_7800, -1);
    single("b2b", ALU_ADD, 32'd10, 32'd20, 32'd30);
    check("b2b_hi", hi, 32'h12);
    check("b2b_lo", lo, 32'h3456_7800);

`ifdef ALU_MDU_DIV_EN
    run_iter("div1", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);
    run_iter("div0", ALU_DIVU, 32'd9,   32'd0, 32'd9, 32'hFFFF_FFFF, -1);
`else
    single("divoff", ALU_DIVU, 32'd100, 32'd7, 32'd0);
    check("divoff_hi", hi, 32'h12);
    check("divoff_lo", lo, 32'h3456_7800);
    tick();
    check("divoff_busy", busy, 0);
`endif

    // Reset 15 cycles into a multiply aborts it and clears everything.
    tick();
    single("pre_rst", ALU_ADD, 32'd40, 32'd2, 32'd42);
    issue(ALU_MULTU, 32'h1234, 32'h10);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_busy", busy,   0);
    check("mrst_done", done,   0);
    check("mrst_hi",   hi,     0);
    check("mrst_lo",   lo,     0);
    check("mrst_res",  result, 0);
    check("mrst_zero", zero,   1);
    single("post_rst", ALU_ADD, 32'd1, 32'd1, 32'd2);
    repeat (40) tick();
    check("post_rst_hi",   hi,     0);
    check("post_rst_res",  result, 2);
    check("post_rst_done", done,   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
